calc_entry: RTL



---
 rtl/calc_pkg.sv | 42 ++++
 rtl/calc_entry_key_event.sv | 45 ++++
 rtl/calc_entry.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared constants, state encoding and small helpers for the calculator entry block.
package calc_pkg;

  localparam int DIGITS_DEF = 4;
  localparam int W_DEF      = 14;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_CLR = 4'd14;
  localparam logic [3:0] KEY_EQ  = 4'd15;

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_B  = 3'd1,
    REQ      = 3'd2,
    WAIT_RES = 3'd3,
    DONE     = 3'd4
  } calc_state_t;

  // Map an operator key index onto the arithmetic unit's op code.
  function automatic logic [1:0] key_to_op(input logic [3:0] code);
    case (code)
      KEY_ADD: return OP_ADD;
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      KEY_DIV: return OP_DIV;
      default: return OP_ADD;
    endcase
  endfunction

  function automatic logic is_op_key(input logic [3:0] code);
    return (code >= KEY_ADD) && (code <= KEY_DIV);
  endfunction

endpackage

// File: rtl/calc_entry_key_event.sv
// Turns the debounced key level vector into single-cycle press events.
// An event fires only for a clean press: exactly one key down, coming from
// all keys up. Chords never fire and block events until every key is released.
module key_event (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] key_vec,
  output logic        evt_valid,
  output logic        evt_is_digit,
  output logic [3:0]  evt_digit,
  output logic [3:0]  evt_code
);

  logic [15:0] key_prev;
  logic        one_hot;
  logic [3:0]  key_idx;

  assign one_hot = (key_vec != 16'd0) && ((key_vec & (key_vec - 16'd1)) == 16'd0);

  // Encode the index of the set bit (only meaningful when one_hot).
  always_comb begin
    key_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (key_vec[i]) key_idx = 4'(i);
    end
  end

  // Register previous levels and the press event with its decoded key.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_prev     <= 16'd0;
      evt_valid    <= 1'b0;
      evt_is_digit <= 1'b0;
      evt_digit    <= 4'd0;
      evt_code     <= 4'd0;
    end else begin
      key_prev     <= key_vec;
      evt_valid    <= one_hot && (key_prev == 16'd0);
      evt_is_digit <= (key_idx < 4'd10);
      evt_digit    <= key_idx;
      evt_code     <= key_idx;
    end
  end

endmodule

// File: rtl/calc_entry.sv
// Calculator key-entry controller: builds operands from digit presses,
// latches the operator, hands the request to the arithmetic unit and
// drives the display value.
//
// Request handshake: calc_valid rises when the request is issued and stays
// high, with operand_a/operand_b/op held stable, until a cycle in which
// calc_ready is also high; that cycle is the transfer and calc_valid drops
// on the following edge. The result comes back later as a one-cycle
// result_valid pulse qualified by result_err.
module calc_entry
  import calc_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int W      = W_DEF,
  parameter int MAXV   = 9999
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [15:0]    key_vec,
  output logic           calc_valid,
  input  logic           calc_ready,
  output logic [W-1:0]   operand_a,
  output logic [W-1:0]   operand_b,
  output logic [1:0]     op,
  input  logic           result_valid,
  input  logic [2*W-1:0] result_in,
  input  logic           result_err,
  output logic [2*W-1:0] disp_value,
  output logic           disp_err,
  output logic           busy,
  output calc_state_t    state_dbg
);

  localparam int XW = W + 4;
  localparam int CW = $clog2(DIGITS + 1);

  logic          evt_valid;
  logic          evt_is_digit;
  logic [3:0]    evt_digit;
  logic [3:0]    evt_code;

  calc_state_t   state;
  logic [CW-1:0] a_cnt;
  logic [CW-1:0] b_cnt;

  logic          clr_evt;
  logic          op_evt;
  logic          eq_evt;
  logic [XW-1:0] a_ext;
  logic [XW-1:0] b_ext;
  logic [W-1:0]  a_next;
  logic [W-1:0]  b_next;
  logic [W-1:0]  sat_a;

  key_event u_key (
    .clk          (clk),
    .rst          (rst),
    .key_vec      (key_vec),
    .evt_valid    (evt_valid),
    .evt_is_digit (evt_is_digit),
    .evt_digit    (evt_digit),
    .evt_code     (evt_code)
  );

  assign clr_evt = evt_valid && (evt_code == KEY_CLR);
  assign op_evt  = evt_valid && is_op_key(evt_code);
  assign eq_evt  = evt_valid && (evt_code == KEY_EQ);

  // Decimal shift-in, computed wide enough that value*10+d cannot wrap.
  assign a_ext  = XW'(operand_a) * XW'(10) + XW'(evt_digit);
  assign b_ext  = XW'(operand_b) * XW'(10) + XW'(evt_digit);
  assign a_next = a_ext[W-1:0];
  assign b_next = b_ext[W-1:0];

  // Chained operand: the DONE-state display register holds the latched result;
  // clamp it into the range an operand can represent.
  always_comb begin
    sat_a = disp_value[W-1:0];
    if (disp_value[2*W-1]) begin
      sat_a = '0;
    end else if (disp_value > (2*W)'(MAXV)) begin
      sat_a = W'(MAXV);
    end
  end

  assign state_dbg = state;

  // Entry FSM with all outputs registered; clear acts like a reset.
  always_ff @(posedge clk) begin
    if (rst || clr_evt) begin
      state      <= ENTER_A;
      operand_a  <= '0;
      operand_b  <= '0;
      a_cnt      <= '0;
      b_cnt      <= '0;
      op         <= OP_ADD;
      calc_valid <= 1'b0;
      busy       <= 1'b0;
      disp_value <= '0;
      disp_err   <= 1'b0;
    end else begin
      case (state)
        ENTER_A: begin
          if (evt_valid && evt_is_digit) begin
            if (a_cnt < CW'(DIGITS)) begin
              operand_a  <= a_next;
              a_cnt      <= a_cnt + 1'b1;
              disp_value <= {{W{1'b0}}, a_next};
            end
          end else if (op_evt) begin
            op        <= key_to_op(evt_code);
            operand_b <= '0;
            b_cnt     <= '0;
            state     <= ENTER_B;
          end
        end

        ENTER_B: begin
          if (evt_valid && evt_is_digit) begin
            if (b_cnt < CW'(DIGITS)) begin
              operand_b  <= b_next;
              b_cnt      <= b_cnt + 1'b1;
              disp_value <= {{W{1'b0}}, b_next};
            end
          end else if (op_evt) begin
            op <= key_to_op(evt_code);
          end else if (eq_evt) begin
            state      <= REQ;
            calc_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end

        REQ: begin
          if (calc_valid && calc_ready) begin
            state      <= WAIT_RES;
            calc_valid <= 1'b0;
          end
        end

        WAIT_RES: begin
          if (result_valid) begin
            disp_value <= result_in;
            disp_err   <= result_err;
            busy       <= 1'b0;
            state      <= DONE;
          end
        end

        DONE: begin
          if (evt_valid && evt_is_digit) begin
            operand_a  <= W'(evt_digit);
            a_cnt      <= CW'(1);
            disp_value <= {{(2*W-4){1'b0}}, evt_digit};
            disp_err   <= 1'b0;
            state      <= ENTER_A;
          end else if (op_evt && !disp_err) begin
            operand_a  <= sat_a;
            a_cnt      <= CW'(DIGITS);
            op         <= key_to_op(evt_code);
            operand_b  <= '0;
            b_cnt      <= '0;
            disp_value <= {{W{1'b0}}, sat_a};
            state      <= ENTER_B;
          end
        end

        default: state <= ENTER_A;
      endcase
    end
  end

endmodule
